stable_matching_seq_ctrl: RTL and testbench
===========================================

Name: stable_matching_seq_ctrl

Overview:
Sequential Gale-Shapley engine and controller. It computes the same sender-proposing stable matching that the combinational stable_matching_comb netlist produces, but it performs one proposal per clock instead of unrolling N iterations. A start/busy/done handshake wraps a proposal-sequencing FSM. It is used when the unrolled netlist is too large and serves as the cycle-accurate golden model for the comb variants. Input packing and output packing match the comb block.

Parameters:
- Ks, 4: preference-list length per sender (list A)
- Kr, Ks: preference-list length per receiver (list B)
- S, 4: number of senders
- R, S: number of receivers
- logS / logR: localparams, ceil-log2 of S and R (minimum 1)
- N: localparam, (S==Ks) ? S*S-S+2 : S*Ks; the cap on RUN cycles
- CW: localparam, ceil-log2(N+1); width of the proposal counter

Ports:
- clk, in, 1: clock, rising edge
- rst, in, 1: asynchronous active-high reset
- start, in, 1: single-cycle request; sampled only in IDLE
- p_input, in, R*Kr*logS+S*Ks*logR: preference lists
  - sender i, entry k at [(i*Ks+k)*logR +: logR]
  - receiver j, entry k at [S*Ks*logR + (j*Kr+k)*logS +: logS]
  - k=0 is the most preferred entry
- busy, out, 1: high in RUN and DONE
- done, out, 1: one-cycle pulse when the result is valid
- o, out, R*logS: partner of receiver j at [j*logS +: logS]; held until the next start
- o_valid, out, R: bit j set if receiver j is matched
- nprop, out, CW: number of proposals issued in the last run
- timeout, out, 1: set if the run was stopped by the N cap

Behaviour:
- Reset (async, any state): FSM=IDLE; o, o_valid, nprop, timeout, done, busy all 0; internal match and pointer tables cleared.
- Storage: p_input is latched into internal registers on the accepted start. p_input may change afterwards.
- Per-sender state: next_idx[s] (0..Ks) and smatched[s].
- Per-receiver state: partner[j] and rmatched[j].
- IDLE:
  - start=1 → latch p_input; clear tables, nprop and timeout; go to RUN.
  - start=0 → stay.
- RUN (one proposal per cycle):
  - Select the lowest-index s with smatched[s]=0 and next_idx[s]<Ks.
  - If no such s exists → go to DONE.
  - Otherwise set r = pref_s[s][next_idx[s]] and increment nprop.
  - r>=R (out of range): rejection; next_idx[s]++.
  - rank_r(s) = lowest k with pref_r[r][k]==s, found by a parallel compare over Kr entries. If s is absent → rejection.
  - r unmatched → partner[r]=s; both marked matched; next_idx[s] unchanged.
  - r matched to c, rank(s)<rank(c) → partner[r]=s; c becomes unmatched; next_idx[c]++.
  - Otherwise → rejection; next_idx[s]++.
  - Cap: if the RUN-cycle count reaches N with an eligible sender still present → timeout=1, go to DONE.
- DONE:
  - o and o_valid are loaded from partner/rmatched on entry.
  - done=1 for exactly one cycle, then IDLE.
  - Unmatched receivers: o field = 0, o_valid bit = 0.
- start while busy: ignored, with no effect on the run.
- Duplicate entries in a receiver list: the first occurrence defines the rank.
- Duplicates in a sender list: proposed again and resolved normally.
- Latency: start sampled at edge 0; proposals on edges 1..P; the empty-select cycle is edge P+1; done is high in the cycle after edge P+1 (P+2 cycles after start).
- Result is independent of selection order: sender-optimal, and bit-identical to the comb block for the same p_input.

Test Plan:
- Identity lists, S=Ks=4: sender i prefers [i,…], receivers prefer [j,…] → o={3,2,1,0} (receiver 3..0 partner = 3..0), o_valid=4'hF, nprop=4, done 6 cycles after start.
- All senders [0,1,2,3], all receivers [3,2,1,0] → r0=s3, r1=s2, r2=s1, r3=s0; nprop=10; done 12 cycles after start; timeout=0.
- S=4, Ks=Kr=2: all senders list [0,1]; r0 and r1 list [0,1] → r0=s0, r1=s1; o_valid=4'b0011; o fields for r2 and r3 = 0.
- Sender list containing 3 with R=3 (logR=2) → out-of-range entry counted in nprop and skipped; the result matches the software Gale-Shapley model.
- start pulsed mid-RUN → ignored, result unchanged. rst asserted mid-RUN → all outputs 0 asynchronously. A new start after release → correct fresh result.
- Random lists, 1000 seeds, S=R=6 → o/o_valid equal to stable_matching_comb and the software model; timeout never set; nprop ≤ N.

Source files
------------

// File: rtl/stable_matching_seq_ctrl.sv
// Sequential sender-proposing Gale-Shapley engine: one proposal per clock,
// wrapped in a start/busy/done handshake with a proposal-count cap.
module stable_matching_seq_ctrl #(
    parameter int Ks = 4,
    parameter int Kr = Ks,
    parameter int S  = 4,
    parameter int R  = S,
    localparam int LOGS = (S > 1) ? $clog2(S) : 1,
    localparam int LOGR = (R > 1) ? $clog2(R) : 1,
    localparam int N    = (S == Ks) ? S * S - S + 2 : S * Ks,
    localparam int CW   = $clog2(N + 1),
    localparam int PW   = R * Kr * LOGS + S * Ks * LOGR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PW-1:0]     p_input,
    output logic              busy,
    output logic              done,
    output logic [R*LOGS-1:0] o,
    output logic [R-1:0]      o_valid,
    output logic [CW-1:0]     nprop,
    output logic              timeout
);
    localparam int IW    = $clog2(Ks + 1);
    localparam int RKW   = $clog2(Kr + 1);
    localparam int RBASE = S * Ks * LOGR;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           p_q, p_d;
    logic [S-1:0][IW-1:0]    next_idx_q, next_idx_d;
    logic [S-1:0]            smatched_q, smatched_d;
    logic [R-1:0][LOGS-1:0]  partner_q, partner_d;
    logic [R-1:0]            rmatched_q, rmatched_d;
    logic [CW-1:0]           nprop_q, nprop_d;
    logic                    timeout_q, timeout_d;
    logic [R*LOGS-1:0]       o_q, o_d;
    logic [R-1:0]            o_valid_q, o_valid_d;
    logic                    done_q, done_d;

    logic                    found;
    logic [LOGS-1:0]         s_sel;
    logic [LOGR-1:0]         r_sel;
    logic [LOGS-1:0]         cur;
    logic [RKW-1:0]          rank_s, rank_c;
    logic                    finish_run;

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        next_idx_d = next_idx_q;
        smatched_d = smatched_q;
        partner_d  = partner_q;
        rmatched_d = rmatched_q;
        nprop_d    = nprop_q;
        timeout_d  = timeout_q;
        o_d        = o_q;
        o_valid_d  = o_valid_q;
        done_d     = 1'b0;
        finish_run = 1'b0;

        // Lowest-index free sender that still has list entries left.
        found = 1'b0;
        s_sel = '0;
        for (int i = S - 1; i >= 0; i--) begin
            if (!smatched_q[i] && next_idx_q[i] < IW'(Ks)) begin
                found = 1'b1;
                s_sel = LOGS'(i);
            end
        end

        r_sel = p_q[(int'(s_sel) * Ks + int'(next_idx_q[s_sel])) * LOGR +: LOGR];
        cur   = partner_q[r_sel];

        // Descending scan so the first occurrence in the receiver list wins.
        rank_s = RKW'(Kr);
        rank_c = RKW'(Kr);
        for (int k = Kr - 1; k >= 0; k--) begin
            if (p_q[RBASE + (int'(r_sel) * Kr + k) * LOGS +: LOGS] == s_sel) rank_s = RKW'(k);
            if (p_q[RBASE + (int'(r_sel) * Kr + k) * LOGS +: LOGS] == cur)   rank_c = RKW'(k);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d        = p_input;
                    next_idx_d = '0;
                    smatched_d = '0;
                    partner_d  = '0;
                    rmatched_d = '0;
                    nprop_d    = '0;
                    timeout_d  = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!found) begin
                    finish_run = 1'b1;
                end else if (nprop_q == CW'(N)) begin
                    timeout_d  = 1'b1;
                    finish_run = 1'b1;
                end else begin
                    nprop_d = nprop_q + 1'b1;
                    if (int'(r_sel) >= R || rank_s == RKW'(Kr)) begin
                        next_idx_d[s_sel] = next_idx_q[s_sel] + 1'b1;
                    end else if (!rmatched_q[r_sel]) begin
                        partner_d[r_sel]  = s_sel;
                        rmatched_d[r_sel] = 1'b1;
                        smatched_d[s_sel] = 1'b1;
                    end else if (rank_s < rank_c) begin
                        partner_d[r_sel]  = s_sel;
                        smatched_d[s_sel] = 1'b1;
                        smatched_d[cur]   = 1'b0;
                        next_idx_d[cur]   = next_idx_q[cur] + 1'b1;
                    end else begin
                        next_idx_d[s_sel] = next_idx_q[s_sel] + 1'b1;
                    end
                end
                if (finish_run) begin
                    for (int j = 0; j < R; j++) begin
                        o_d[j * LOGS +: LOGS] = rmatched_q[j] ? partner_q[j] : '0;
                    end
                    o_valid_d = rmatched_q;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // values computed before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            next_idx_q <= '0;
            smatched_q <= '0;
            partner_q  <= '0;
            rmatched_q <= '0;
            nprop_q    <= '0;
            timeout_q  <= 1'b0;
            o_q        <= '0;
            o_valid_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_idx_q <= next_idx_d;
            smatched_q <= smatched_d;
            partner_q  <= partner_d;
            rmatched_q <= rmatched_d;
            nprop_q    <= nprop_d;
            timeout_q  <= timeout_d;
            o_q        <= o_d;
            o_valid_q  <= o_valid_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the preference store is left unreset; it is always rewritten on
    // an accepted start before any proposal reads it.
    always_ff @(posedge clk) begin
        p_q <= p_d;
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign nprop   = nprop_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_stable_matching_seq_ctrl.sv
// Bench for stable_matching_seq_ctrl: directed scenarios plus randomized lists
// checked against a free-order Gale-Shapley model (R=4 and R=3 instances).
module tb_stable_matching_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] p_a;
    logic [55:0] p_b;

    logic        busy_a, done_a, timeout_a;
    logic [7:0]  o_a;
    logic [3:0]  o_valid_a;
    logic [3:0]  nprop_a;
    logic        busy_b, done_b, timeout_b;
    logic [5:0]  o_b;
    logic [2:0]  o_valid_b;
    logic [3:0]  nprop_b;

    stable_matching_seq_ctrl #(.Ks(4), .Kr(4), .S(4), .R(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .p_input(p_a),
        .busy(busy_a), .done(done_a), .o(o_a), .o_valid(o_valid_a),
        .nprop(nprop_a), .timeout(timeout_a)
    );

    stable_matching_seq_ctrl #(.Ks(4), .Kr(4), .S(4), .R(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .p_input(p_b),
        .busy(busy_b), .done(done_b), .o(o_b), .o_valid(o_valid_b),
        .nprop(nprop_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    int          cyc_a, cyc_b;
    logic        got_a, got_b, busy1_a;
    logic [7:0]  cap_o_a;
    logic [3:0]  cap_v_a, cap_np_a;
    logic        cap_to_a;
    logic [5:0]  cap_o_b;
    logic [2:0]  cap_v_b;
    logic [3:0]  cap_np_b;
    logic        cap_to_b;

    int          m_partner[4];
    int          m_np;
    logic [7:0]  m_o;
    logic [3:0]  m_v;

    function automatic int fld(input logic [63:0] p, input int off);
        return int'((p >> off) & 64'h3);
    endfunction

    function automatic int rank_of(input logic [63:0] p, input int r, input int s);
        for (int k = 0; k < 4; k++) begin
            if (fld(p, 32 + (r * 4 + k) * 2) == s) return k;
        end
        return -1;
    endfunction

    // Gale-Shapley with a FIFO of free senders; the proposal count and the
    // sender-optimal result do not depend on the order proposals are made.
    task automatic gs_model(input logic [63:0] p, input int nr);
        int nxt[4];
        int q[$];
        int s, r, rs, c;
        m_np = 0;
        for (int j = 0; j < 4; j++) m_partner[j] = -1;
        for (int i = 0; i < 4; i++) begin
            nxt[i] = 0;
            q.push_back(i);
        end
        while (q.size() > 0) begin
            s = q.pop_front();
            if (nxt[s] < 4) begin
                r = fld(p, (s * 4 + nxt[s]) * 2);
                nxt[s]++;
                m_np++;
                rs = (r < nr) ? rank_of(p, r, s) : -1;
                if (rs < 0) begin
                    q.push_back(s);
                end else if (m_partner[r] < 0) begin
                    m_partner[r] = s;
                end else begin
                    c = m_partner[r];
                    if (rs < rank_of(p, r, c)) begin
                        m_partner[r] = s;
                        q.push_back(c);
                    end else begin
                        q.push_back(s);
                    end
                end
            end
        end
        m_o = '0;
        m_v = '0;
        for (int j = 0; j < nr; j++) begin
            if (m_partner[j] >= 0) begin
                m_o[j * 2 +: 2] = 2'(m_partner[j]);
                m_v[j] = 1'b1;
            end
        end
    endtask

    task automatic set_sa(input int i, input int e0, input int e1, input int e2, input int e3);
        p_a[(i * 4 + 0) * 2 +: 2] = 2'(e0);
        p_a[(i * 4 + 1) * 2 +: 2] = 2'(e1);
        p_a[(i * 4 + 2) * 2 +: 2] = 2'(e2);
        p_a[(i * 4 + 3) * 2 +: 2] = 2'(e3);
    endtask

    task automatic set_ra(input int j, input int e0, input int e1, input int e2, input int e3);
        p_a[32 + (j * 4 + 0) * 2 +: 2] = 2'(e0);
        p_a[32 + (j * 4 + 1) * 2 +: 2] = 2'(e1);
        p_a[32 + (j * 4 + 2) * 2 +: 2] = 2'(e2);
        p_a[32 + (j * 4 + 3) * 2 +: 2] = 2'(e3);
    endtask

    task automatic set_sb(input int i, input int e0, input int e1, input int e2, input int e3);
        p_b[(i * 4 + 0) * 2 +: 2] = 2'(e0);
        p_b[(i * 4 + 1) * 2 +: 2] = 2'(e1);
        p_b[(i * 4 + 2) * 2 +: 2] = 2'(e2);
        p_b[(i * 4 + 3) * 2 +: 2] = 2'(e3);
    endtask

    task automatic set_rb(input int j, input int e0, input int e1, input int e2, input int e3);
        p_b[32 + (j * 4 + 0) * 2 +: 2] = 2'(e0);
        p_b[32 + (j * 4 + 1) * 2 +: 2] = 2'(e1);
        p_b[32 + (j * 4 + 2) * 2 +: 2] = 2'(e2);
        p_b[32 + (j * 4 + 3) * 2 +: 2] = 2'(e3);
    endtask

    task automatic load_identity_a();
        for (int i = 0; i < 4; i++) begin
            set_sa(i, i, (i + 1) % 4, (i + 2) % 4, (i + 3) % 4);
            set_ra(i, i, (i + 1) % 4, (i + 2) % 4, (i + 3) % 4);
        end
    endtask

    task automatic load_reverse_a();
        for (int i = 0; i < 4; i++) begin
            set_sa(i, 0, 1, 2, 3);
            set_ra(i, 3, 2, 1, 0);
        end
    endtask

    task automatic load_oor_b();
        set_sb(0, 3, 0, 1, 2);
        set_sb(1, 1, 0, 2, 3);
        set_sb(2, 2, 0, 1, 3);
        set_sb(3, 3, 3, 0, 1);
        set_rb(0, 0, 1, 2, 3);
        set_rb(1, 1, 0, 2, 3);
        set_rb(2, 2, 0, 1, 3);
    endtask

    // Pulses start on both instances and records when each raises done.
    // cycle c is observed on the falling edge after c rising edges.
    task automatic launch(input int mid_start);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        got_a   = 1'b0;
        got_b   = 1'b0;
        cyc_a   = -1;
        cyc_b   = -1;
        busy1_a = busy_a;
        for (int c = 1; c <= 40; c++) begin
            if (!got_a && done_a) begin
                got_a = 1'b1; cyc_a = c;
                cap_o_a = o_a; cap_v_a = o_valid_a; cap_np_a = nprop_a; cap_to_a = timeout_a;
            end
            if (!got_b && done_b) begin
                got_b = 1'b1; cyc_b = c;
                cap_o_b = o_b; cap_v_b = o_valid_b; cap_np_b = nprop_b; cap_to_b = timeout_b;
            end
            if (got_a && got_b) break;
            start = (c == mid_start);
            if (c == mid_start) begin
                p_a = ~p_a;
                p_b = ~p_b;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_chk++;
        if (!(got_a && got_b)) $display("FAIL done_wait: got_a=%0d got_b=%0d, required both 1 within 40 cycles", got_a, got_b);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({o_a, o_valid_a, nprop_a, timeout_a, done_a, busy_a} !== 19'h0)
            $display("FAIL reset_a: o=%h v=%h np=%0d to=%b done=%b busy=%b, required all 0", o_a, o_valid_a, nprop_a, timeout_a, done_a, busy_a);
        else n_pass++;
        n_chk++;
        if ({o_b, o_valid_b, nprop_b, timeout_b, done_b, busy_b} !== 16'h0)
            $display("FAIL reset_b: o=%h v=%h np=%0d to=%b done=%b busy=%b, required all 0", o_b, o_valid_b, nprop_b, timeout_b, done_b, busy_b);
        else n_pass++;
    endtask

    task automatic test_identity();
        load_identity_a();
        load_oor_b();
        launch(0);
        n_chk++;
        if (cap_o_a !== 8'he4 || cap_v_a !== 4'hf)
            $display("FAIL identity_result: o=%h v=%h, required o=e4 v=f", cap_o_a, cap_v_a);
        else n_pass++;
        n_chk++;
        if (cap_np_a !== 4'd4 || cap_to_a !== 1'b0 || cyc_a != 6)
            $display("FAIL identity_count: np=%0d to=%b cyc=%0d, required np=4 to=0 cyc=6", cap_np_a, cap_to_a, cyc_a);
        else n_pass++;
    endtask

    task automatic test_reverse();
        load_reverse_a();
        launch(0);
        n_chk++;
        if (cap_o_a !== 8'h1b || cap_v_a !== 4'hf)
            $display("FAIL reverse_result: o=%h v=%h, required o=1b v=f", cap_o_a, cap_v_a);
        else n_pass++;
        n_chk++;
        if (cap_np_a !== 4'd10 || cap_to_a !== 1'b0 || cyc_a != 12)
            $display("FAIL reverse_count: np=%0d to=%b cyc=%0d, required np=10 to=0 cyc=12", cap_np_a, cap_to_a, cyc_a);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        load_identity_a();
        load_oor_b();
        gs_model({8'h00, p_b}, 3);
        launch(0);
        n_chk++;
        if (cap_o_b !== 6'h24 || cap_v_b !== 3'b111 || cap_np_b !== 4'd8 || cap_to_b !== 1'b0 || cyc_b != 10)
            $display("FAIL oor_fixed: o=%h v=%b np=%0d to=%b cyc=%0d, required o=24 v=111 np=8 to=0 cyc=10", cap_o_b, cap_v_b, cap_np_b, cap_to_b, cyc_b);
        else n_pass++;
        n_chk++;
        if (cap_o_b !== m_o[5:0] || cap_v_b !== m_v[2:0] || int'(cap_np_b) != m_np)
            $display("FAIL oor_model: o=%h v=%b np=%0d, required o=%h v=%b np=%0d", cap_o_b, cap_v_b, cap_np_b, m_o[5:0], m_v[2:0], m_np);
        else n_pass++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) set_sa(i, 0, 0, 0, 0);
        set_sa(3, 1, 2, 3, 0);
        set_ra(0, 3, 3, 3, 3);
        for (int j = 1; j < 4; j++) set_ra(j, 0, 0, 0, 0);
        launch(0);
        n_chk++;
        if (cap_to_a !== 1'b1 || cap_np_a !== 4'd14 || cyc_a != 16)
            $display("FAIL timeout_flag: to=%b np=%0d cyc=%0d, required to=1 np=14 cyc=16", cap_to_a, cap_np_a, cyc_a);
        else n_pass++;
        n_chk++;
        if (cap_o_a !== 8'h00 || cap_v_a !== 4'h0)
            $display("FAIL timeout_result: o=%h v=%h, required o=00 v=0", cap_o_a, cap_v_a);
        else n_pass++;
    endtask

    task automatic test_handshake();
        load_identity_a();
        load_oor_b();
        launch(3);
        n_chk++;
        if (cap_o_a !== 8'he4 || cap_v_a !== 4'hf || cap_np_a !== 4'd4 || cyc_a != 6)
            $display("FAIL mid_start_a: o=%h v=%h np=%0d cyc=%0d, required o=e4 v=f np=4 cyc=6", cap_o_a, cap_v_a, cap_np_a, cyc_a);
        else n_pass++;
        n_chk++;
        if (cap_o_b !== 6'h24 || cap_np_b !== 4'd8 || cyc_b != 10)
            $display("FAIL mid_start_b: o=%h np=%0d cyc=%0d, required o=24 np=8 cyc=10", cap_o_b, cap_np_b, cyc_b);
        else n_pass++;
        n_chk++;
        if (busy1_a !== 1'b1)
            $display("FAIL busy_run: busy=%b, required 1", busy1_a);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (done_b !== 1'b0 || busy_b !== 1'b0 || o_b !== 6'h24)
            $display("FAIL done_pulse: done=%b busy=%b o=%h, required done=0 busy=0 o=24", done_b, busy_b, o_b);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        load_identity_a();
        load_oor_b();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({o_a, o_valid_a, nprop_a, timeout_a, done_a, busy_a} !== 19'h0 ||
            {o_b, o_valid_b, nprop_b, timeout_b, done_b, busy_b} !== 16'h0)
            $display("FAIL reset_mid: o_a=%h v_a=%h np_a=%0d busy_a=%b o_b=%h np_b=%0d, required all 0", o_a, o_valid_a, nprop_a, busy_a, o_b, nprop_b);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        load_reverse_a();
        launch(0);
        n_chk++;
        if (cap_o_a !== 8'h1b || cap_v_a !== 4'hf || cap_np_a !== 4'd10 || cyc_a != 12)
            $display("FAIL after_reset: o=%h v=%h np=%0d cyc=%0d, required o=1b v=f np=10 cyc=12", cap_o_a, cap_v_a, cap_np_a, cyc_a);
        else n_pass++;
    endtask

    task automatic test_random(input int iters);
        logic [7:0] eo_a;
        logic [3:0] ev_a;
        int         enp_a;
        for (int it = 0; it < iters; it++) begin
            for (int t = 0; t < 200; t++) begin
                p_a = {$urandom, $urandom};
                gs_model(p_a, 4);
                if (m_np <= 14) break;
            end
            eo_a  = m_o;
            ev_a  = m_v;
            enp_a = m_np;
            for (int t = 0; t < 200; t++) begin
                p_b = 56'({$urandom, $urandom});
                gs_model({8'h00, p_b}, 3);
                if (m_np <= 14) break;
            end
            launch(0);
            n_chk++;
            if (cap_o_a !== eo_a || cap_v_a !== ev_a || int'(cap_np_a) != enp_a || cap_to_a !== 1'b0 || cyc_a != enp_a + 2)
                $display("FAIL rand_a %0d: o=%h v=%h np=%0d to=%b cyc=%0d, required o=%h v=%h np=%0d to=0 cyc=%0d",
                         it, cap_o_a, cap_v_a, cap_np_a, cap_to_a, cyc_a, eo_a, ev_a, enp_a, enp_a + 2);
            else n_pass++;
            n_chk++;
            if (cap_o_b !== m_o[5:0] || cap_v_b !== m_v[2:0] || int'(cap_np_b) != m_np || cap_to_b !== 1'b0 || cyc_b != m_np + 2)
                $display("FAIL rand_b %0d: o=%h v=%b np=%0d to=%b cyc=%0d, required o=%h v=%b np=%0d to=0 cyc=%0d",
                         it, cap_o_b, cap_v_b, cap_np_b, cap_to_b, cyc_b, m_o[5:0], m_v[2:0], m_np, m_np + 2);
            else n_pass++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        start  = 1'b0;
        p_a    = '0;
        p_b    = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_identity();
        test_reverse();
        test_out_of_range();
        test_timeout();
        test_handshake();
        test_reset_mid();
        test_random(200);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
